// File: rtl/led_pwm_fader.sv
// Soft-fade LED driver: each channel ramps a brightness level toward its pattern bit
// and is rendered by PWM against a shared free-running counter.
module led_pwm_fader #(
    parameter int N_LED    = 8,
    parameter int PWM_BITS = 8,
    parameter int RAMP_DIV = 4096
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             enable,
    input  logic [N_LED-1:0] pattern_in,
    output logic [N_LED-1:0] led_out,
    output logic             busy
);

    localparam int                  RAMP_W    = $clog2(RAMP_DIV);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    // PWM period is MAX cycles so that level MAX compares high on every count.
    localparam logic [PWM_BITS-1:0] PWM_LAST  = LEVEL_MAX - 1'b1;
    localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

    logic [N_LED-1:0]    pat_q;
    logic [PWM_BITS-1:0] level [N_LED];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [RAMP_W-1:0]   ramp_cnt;
    logic                ramp_tick;
    logic [N_LED-1:0]    at_target;

    assign ramp_tick = (ramp_cnt == RAMP_LAST);

    always_comb begin
        at_target = '0;
        for (int i = 0; i < N_LED; i++) begin
            at_target[i] = pat_q[i] ? (level[i] == LEVEL_MAX) : (level[i] == '0);
        end
    end

    // The input register keeps tracking the pattern even while disabled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pat_q <= '0;
        end else begin
            pat_q <= pattern_in;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pwm_cnt  <= '0;
            ramp_cnt <= '0;
        end else if (!enable) begin
            pwm_cnt  <= '0;
            ramp_cnt <= '0;
        end else begin
            pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
            ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
        end
    end

    // Target is either full or dark, so a step is only needed when not already there.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_LED; i++) begin
                level[i] <= '0;
            end
        end else if (!enable) begin
            for (int i = 0; i < N_LED; i++) begin
                level[i] <= '0;
            end
        end else if (ramp_tick) begin
            for (int i = 0; i < N_LED; i++) begin
                if (!at_target[i]) begin
                    level[i] <= pat_q[i] ? level[i] + 1'b1 : level[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            led_out <= '0;
            busy    <= 1'b0;
        end else if (!enable) begin
            led_out <= '0;
            busy    <= 1'b0;
        end else begin
            for (int i = 0; i < N_LED; i++) begin
                led_out[i] <= (level[i] > pwm_cnt);
            end
            busy <= ~&at_target;
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Randomized self-checking bench for led_pwm_fader against a cycle-level arithmetic model.
module tb_led_pwm_fader;

    localparam int N_LED    = 8;
    localparam int PWM_BITS = 3;
    localparam int RAMP_DIV = 4;
    localparam int MAX      = 7;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] pattern_in = 8'h00;
    logic [7:0] led_out;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: brightness per channel plus the number of enabled edges since the last clear.
    int         mLevel [N_LED];
    logic [7:0] mPat;
    int         enCycles;
    logic [7:0] expLed;
    logic       expBusy;

    always #5 aclk = ~aclk;

    led_pwm_fader #(
        .N_LED   (N_LED),
        .PWM_BITS(PWM_BITS),
        .RAMP_DIV(RAMP_DIV)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .enable    (enable),
        .pattern_in(pattern_in),
        .led_out   (led_out),
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] pat);
        enable     = en;
        pattern_in = pat;
    endtask

    function automatic void modelReset();
        for (int i = 0; i < N_LED; i++) mLevel[i] = 0;
        mPat     = 8'h00;
        enCycles = 0;
        expLed   = 8'h00;
        expBusy  = 1'b0;
    endfunction

    function automatic void modelEdge();
        logic [7:0] nextLed;
        logic       nextBusy;
        int         target;
        if (!enable) begin
            for (int i = 0; i < N_LED; i++) mLevel[i] = 0;
            enCycles = 0;
            expLed   = 8'h00;
            expBusy  = 1'b0;
        end else begin
            nextLed  = 8'h00;
            nextBusy = 1'b0;
            for (int i = 0; i < N_LED; i++) begin
                target     = mPat[i] ? MAX : 0;
                nextLed[i] = (mLevel[i] > (enCycles % MAX));
                if (mLevel[i] != target) nextBusy = 1'b1;
            end
            if ((enCycles % RAMP_DIV) == RAMP_DIV - 1) begin
                for (int i = 0; i < N_LED; i++) begin
                    target = mPat[i] ? MAX : 0;
                    if (mLevel[i] < target) mLevel[i] = mLevel[i] + 1;
                    else if (mLevel[i] > target) mLevel[i] = mLevel[i] - 1;
                end
            end
            expLed   = nextLed;
            expBusy  = nextBusy;
            enCycles = enCycles + 1;
        end
        mPat = pattern_in;
    endfunction

    task automatic runCycle();
        @(posedge aclk);
        if (!aresetn) modelReset();
        else modelEdge();
        @(negedge aclk);
        checkOutput("led_out", {24'h0, led_out}, {24'h0, expLed});
        checkOutput("busy", {31'h0, busy}, {31'h0, expBusy});
    endtask

    initial begin
        int         highs;
        int         guard;
        logic [7:0] lfsr;

        modelReset();
        applyStimulus(1'b0, 8'h00);
        repeat (2) @(negedge aclk);
        checkOutput("reset_led", {24'h0, led_out}, 32'h0);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        aresetn = 1'b1;

        // Fade-in of channel 0 only.
        applyStimulus(1'b1, 8'h01);
        repeat (32) runCycle();
        checkOutput("fadein_led", {24'h0, led_out}, 32'h01);
        checkOutput("fadein_busy", {31'h0, busy}, 32'h0);
        highs = 0;
        for (int c = 0; c < 2 * MAX; c++) begin
            runCycle();
            highs += int'(led_out[0]);
        end
        checkOutput("full_duty", highs, 2 * MAX);

        // Fade out, then climb to level 4 and reverse.
        applyStimulus(1'b1, 8'h00);
        repeat (34) runCycle();
        checkOutput("dark_led", {24'h0, led_out}, 32'h0);
        applyStimulus(1'b1, 8'h01);
        guard = 0;
        while (mLevel[0] != 4 && guard < 100) begin
            runCycle();
            guard++;
        end
        checkOutput("reach4_timeout", {31'h0, guard >= 100}, 32'h0);
        applyStimulus(1'b1, 8'h00);
        repeat (30) runCycle();
        checkOutput("reverse_led", {24'h0, led_out}, 32'h0);
        checkOutput("reverse_busy", {31'h0, busy}, 32'h0);

        // Asynchronous reset in the middle of a ramp.
        applyStimulus(1'b1, 8'hFF);
        repeat (13) runCycle();
        #2 aresetn = 1'b0;
        #1;
        checkOutput("async_reset_led", {24'h0, led_out}, 32'h0);
        checkOutput("async_reset_busy", {31'h0, busy}, 32'h0);
        modelReset();
        repeat (2) runCycle();
        aresetn = 1'b1;

        // Enable drop exactly on a ramp tick at level 5.
        guard = 0;
        while (!(mLevel[0] == 5 && (enCycles % RAMP_DIV) == RAMP_DIV - 1) && guard < 100) begin
            runCycle();
            guard++;
        end
        checkOutput("reach5_timeout", {31'h0, guard >= 100}, 32'h0);
        applyStimulus(1'b0, 8'hFF);
        runCycle();
        checkOutput("drop_led", {24'h0, led_out}, 32'h0);
        checkOutput("drop_busy", {31'h0, busy}, 32'h0);
        applyStimulus(1'b1, 8'hFF);
        repeat (32) runCycle();
        checkOutput("refade_led", {24'h0, led_out}, 32'hFF);
        checkOutput("refade_busy", {31'h0, busy}, 32'h0);

        // Random patterns from an LFSR, with occasional enable drops.
        lfsr = 8'($urandom_range(1, 255));
        for (int c = 0; c < 2048; c++) begin
            if (c % 64 == 0) lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            applyStimulus(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, lfsr);
            runCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
